// File: rtl/alu_shift_pkg.sv
// Shared definitions for the multi-cycle shift/rotate unit. The ALU decode
// and the bench use these as well.
//   op codes      : SHR, SHRA, SHL, ROR, ROL (5..7 illegal)
//   state codes   : IDLE, BUSY, DONE
//   clog2()       : constant-foldable ceil(log2) used to size stages/counters
package alu_shift_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_SHR  = 3'd0;
  localparam op_t OP_SHRA = 3'd1;
  localparam op_t OP_SHL  = 3'd2;
  localparam op_t OP_ROR  = 3'd3;
  localparam op_t OP_ROL  = 3'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_shift_group.sv
// One group of barrel stages, purely combinational. The top feeds the work
// register through this block once per clock; input g selects which stages
// (k with k/SPC == g) are active this cycle. Stage k moves by 2^k when
// count[k] is set, and active stages are applied in ascending k.
//   data   : current work value
//   count  : shift amount, low log2(WIDTH) bits
//   op     : operation code
//   fill   : bit shifted in from the top for right shifts (sign for SHRA)
//   g      : group index
//   result : data after this group's stages
module alu_shift_group
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SPC   = 1,
  localparam int L    = clog2(WIDTH),
  localparam int G    = (L + SPC - 1) / SPC,
  localparam int GW   = (G > 1) ? clog2(G) : 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [L-1:0]     count,
  input  op_t              op,
  input  logic             fill,
  input  logic [GW-1:0]    g,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] stage_d;

  always_comb begin
    stage_d = data;
    for (int k = 0; k < L; k++) begin
      if ((g == GW'(k / SPC)) && count[k]) begin
        case (op)
          OP_SHR, OP_SHRA:
            stage_d = (stage_d >> (1 << k)) |
                      ({WIDTH{fill}} & ~({WIDTH{1'b1}} >> (1 << k)));
          OP_SHL:
            stage_d = stage_d << (1 << k);
          OP_ROR:
            stage_d = (stage_d >> (1 << k)) | (stage_d << (WIDTH - (1 << k)));
          OP_ROL:
            stage_d = (stage_d << (1 << k)) | (stage_d >> (WIDTH - (1 << k)));
          default:
            stage_d = stage_d;
        endcase
      end
    end
    result = stage_d;
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle shift/rotate unit (SHR, SHRA, SHL, ROR, ROL) with a
// start/busy/done handshake. Works through log2(WIDTH) barrel stages,
// STAGES_PER_CYCLE per clock, via a single alu_shift_group fed back through
// the work register. The result register holds until the next final edge.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : request, honoured only in IDLE or DONE
//   op, a, b   : operation, operand, unsigned count (sampled on accept only)
//   busy       : high while an operation is in flight
//   done       : one-cycle result-valid pulse
//   c, z       : registered result and (c == 0)
//   op_err     : registered, set with done when op was illegal
//
// state | meaning
// IDLE  | waiting for start
// BUSY  | applying one stage group per clock
// DONE  | result valid for one cycle; start here is accepted back-to-back
module alu_shift_seq
  import alu_shift_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int STAGES_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c,
  output logic             z,
  output logic             op_err
);

  localparam int L  = clog2(WIDTH);
  localparam int G  = (L + STAGES_PER_CYCLE - 1) / STAGES_PER_CYCLE;
  localparam int GW = (G > 1) ? clog2(G) : 1;

  logic [1:0]       state;
  logic [GW-1:0]    g_cnt;
  logic [WIDTH-1:0] work;
  logic [L-1:0]     cnt;
  op_t              op_r;
  logic             fill_r;
  logic             sat_r;

  logic [WIDTH-1:0] grp_out;
  logic [WIDTH-1:0] final_c;
  logic             accept;
  logic             last_grp;
  logic             is_shift;
  logic             legal;

  alu_shift_group #(
    .WIDTH (WIDTH),
    .SPC   (STAGES_PER_CYCLE)
  ) u_group (
    .data   (work),
    .count  (cnt),
    .op     (op_r),
    .fill   (fill_r),
    .g      (g_cnt),
    .result (grp_out)
  );

  assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_grp = (g_cnt == GW'(G - 1));
  assign busy     = (state == ST_BUSY);
  assign done     = (state == ST_DONE);

  // Counts of WIDTH or more saturate shifts to all-fill; rotates just use
  // the low L count bits, i.e. count mod WIDTH.
  always_comb begin
    is_shift = (op_r == OP_SHR) || (op_r == OP_SHRA) || (op_r == OP_SHL);
    legal    = (op_r <= OP_ROL);
    if (!legal)
      final_c = '0;
    else if (is_shift && sat_r)
      final_c = {WIDTH{fill_r}};
    else
      final_c = grp_out;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      g_cnt  <= '0;
      work   <= '0;
      cnt    <= '0;
      op_r   <= OP_SHR;
      fill_r <= 1'b0;
      sat_r  <= 1'b0;
      c      <= '0;
      z      <= 1'b1;
      op_err <= 1'b0;
    end else if (accept) begin
      op_r   <= op;
      work   <= a;
      cnt    <= b[L-1:0];
      sat_r  <= |b[WIDTH-1:L];
      fill_r <= (op == OP_SHRA) && a[WIDTH-1];
      g_cnt  <= '0;
      state  <= ST_BUSY;
    end else begin
      case (state)
        ST_BUSY: begin
          work <= grp_out;
          if (last_grp) begin
            c      <= final_c;
            z      <= (final_c == '0);
            op_err <= !legal;
            state  <= ST_DONE;
          end else begin
            g_cnt <= g_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
